smaqa_issue_ctrl: RTL and testbench

//  Sequences one SMAQA (rd += sum of 4 signed 8x8 byte products of rs1,rs2) at a time around the multiplier.

---
 rtl/smaqa_ctrl_pkg.sv | 24 ++
 rtl/smaqa_wdog.sv | 26 ++
 rtl/smaqa_issue_ctrl.sv | 179 +++++++++++++++++
 tb/tb_smaqa_issue_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/smaqa_ctrl_pkg.sv
// Shared types for the SMAQA issue controller: FSM states, latched request and watchdog width.
package smaqa_ctrl_pkg;

    localparam int TRANS_ID_BITS = 3;
    // Watchdog counter width; TIMEOUT_CYCLES must fit below 2**TMO_W.
    localparam int TMO_W         = 8;

    typedef enum logic [2:0] {
        IDLE,
        RD_AB,
        RD_C,
        ISSUE,
        WAIT,
        WB
    } state_e;

    typedef struct packed {
        logic [4:0]               rs1;
        logic [4:0]               rs2;
        logic [4:0]               rd;
        logic [TRANS_ID_BITS-1:0] trans_id;
    } smaqa_req_t;

endpackage

// File: rtl/smaqa_wdog.sv
// Result watchdog: counts cycles while enabled, flags the last allowed cycle (count == LIMIT-1).
module smaqa_wdog
    import smaqa_ctrl_pkg::*;
#(
    parameter int LIMIT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    logic [TMO_W-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_cnt <= '0;
        end else if (en_i) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expire_o = en_i && (r_cnt == TMO_W'(LIMIT - 1));

endmodule

// File: rtl/smaqa_issue_ctrl.sv
// Sequences one SMAQA (rd += dot4 of signed bytes) around a 2-read-port regfile and the multiplier.
// Optional macro SMAQA_FWD_EN: forwards the last written rd so back-to-back accumulation skips RD_C.
module smaqa_issue_ctrl
    import smaqa_ctrl_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [4:0]               req_rs1_i,
    input  logic [4:0]               req_rs2_i,
    input  logic [4:0]               req_rd_i,
    input  logic [TRANS_ID_BITS-1:0] req_trans_id_i,
    output logic [1:0][4:0]          rf_raddr_o,
    input  logic [1:0][XLEN-1:0]     rf_rdata_i,
    output logic                     mult_valid_o,
    input  logic                     mult_ready_i,
    output logic [XLEN-1:0]          mult_op_a_o,
    output logic [XLEN-1:0]          mult_op_b_o,
    output logic [XLEN-1:0]          mult_op_c_o,
    output logic [TRANS_ID_BITS-1:0] mult_trans_id_o,
    input  logic                     mult_valid_i,
    input  logic [XLEN-1:0]          mult_result_i,
    input  logic [TRANS_ID_BITS-1:0] mult_trans_id_i,
    output logic                     rf_we_o,
    output logic [4:0]               rf_waddr_o,
    output logic [XLEN-1:0]          rf_wdata_o,
    output logic                     done_valid_o,
    output logic [TRANS_ID_BITS-1:0] done_trans_id_o,
    output logic                     err_o
);

    state_e           r_state;
    smaqa_req_t       r_req;
    logic [XLEN-1:0]  r_a, r_b, r_c, r_wdata;
    logic             r_mv, r_we, r_done, r_err;

    logic             w_expire, w_hit, w_timeout;
    logic             w_fwd_a, w_fwd_b, w_skip_c;
    logic [XLEN-1:0]  w_fwd_val, w_a, w_b, w_c;

    smaqa_wdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (r_state != WAIT),
        .en_i     (r_state == WAIT),
        .expire_o (w_expire)
    );

    // A matching result in the final cycle beats the watchdog.
    assign w_hit     = mult_valid_i && (mult_trans_id_i == r_req.trans_id);
    assign w_timeout = (r_state == WAIT) && !w_hit && w_expire;

`ifdef SMAQA_FWD_EN
    logic             r_fwd_vld;
    logic [4:0]       r_fwd_rd;
    logic [XLEN-1:0]  r_fwd_val;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fwd_vld <= 1'b0;
            r_fwd_rd  <= '0;
            r_fwd_val <= '0;
        end else if (r_we) begin
            r_fwd_vld <= 1'b1;
            r_fwd_rd  <= r_req.rd;
            r_fwd_val <= r_wdata;
        end else if (w_timeout) begin
            r_fwd_vld <= 1'b0;
        end
    end

    assign w_fwd_a   = r_fwd_vld && (r_fwd_rd == r_req.rs1);
    assign w_fwd_b   = r_fwd_vld && (r_fwd_rd == r_req.rs2);
    assign w_skip_c  = r_fwd_vld && (r_fwd_rd == r_req.rd) && (r_req.rd != '0);
    assign w_fwd_val = r_fwd_val;
`else
    assign w_fwd_a   = 1'b0;
    assign w_fwd_b   = 1'b0;
    assign w_skip_c  = 1'b0;
    assign w_fwd_val = '0;
`endif

    // x0 reads as zero no matter what the regfile returns.
    assign w_a = (r_req.rs1 == '0) ? '0 : (w_fwd_a ? w_fwd_val : rf_rdata_i[0]);
    assign w_b = (r_req.rs2 == '0) ? '0 : (w_fwd_b ? w_fwd_val : rf_rdata_i[1]);
    assign w_c = (r_req.rd  == '0) ? '0 : rf_rdata_i[0];

    always_comb begin
        rf_raddr_o = '0;
        if (r_state == RD_AB) begin
            rf_raddr_o[0] = r_req.rs1;
            rf_raddr_o[1] = r_req.rs2;
        end else if (r_state == RD_C) begin
            rf_raddr_o[0] = r_req.rd;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_req   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_wdata <= '0;
            r_mv    <= 1'b0;
            r_we    <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid_i) begin
                        r_req   <= '{rs1: req_rs1_i, rs2: req_rs2_i, rd: req_rd_i,
                                     trans_id: req_trans_id_i};
                        r_state <= RD_AB;
                    end
                end
                RD_AB: begin
                    r_a <= w_a;
                    r_b <= w_b;
                    if (w_skip_c) begin
                        r_c     <= w_fwd_val;
                        r_mv    <= 1'b1;
                        r_state <= ISSUE;
                    end else begin
                        r_state <= RD_C;
                    end
                end
                RD_C: begin
                    r_c     <= w_c;
                    r_mv    <= 1'b1;
                    r_state <= ISSUE;
                end
                ISSUE: begin
                    if (mult_ready_i) begin
                        r_mv    <= 1'b0;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (w_hit) begin
                        r_wdata <= mult_result_i;
                        r_we    <= (r_req.rd != '0);
                        r_done  <= 1'b1;
                        r_state <= WB;
                    end else if (w_expire) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                WB:      r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready_o     = (r_state == IDLE);
    assign mult_valid_o    = r_mv;
    assign mult_op_a_o     = r_a;
    assign mult_op_b_o     = r_b;
    assign mult_op_c_o     = r_c;
    assign mult_trans_id_o = r_req.trans_id;
    assign rf_we_o         = r_we;
    assign rf_waddr_o      = r_req.rd;
    assign rf_wdata_o      = r_wdata;
    assign done_valid_o    = r_done;
    assign done_trans_id_o = r_req.trans_id;
    assign err_o           = r_err;

endmodule

// File: tb/tb_smaqa_issue_ctrl.sv
// Directed + randomized bench for smaqa_issue_ctrl with a regfile model and a multiplier stub.
module tb_smaqa_issue_ctrl;
    import smaqa_ctrl_pkg::*;

    localparam int XLEN = 32;
    localparam int T    = 16;

    logic                     clk;
    logic                     rst;
    logic                     req_valid, ready;
    logic [4:0]               rs1, rs2, rd;
    logic [TRANS_ID_BITS-1:0] tid;
    logic [1:0][4:0]          raddr;
    logic [1:0][XLEN-1:0]     rdata;
    logic                     mv, mready;
    logic [XLEN-1:0]          opa, opb, opc;
    logic [TRANS_ID_BITS-1:0] mtid_o;
    logic                     mvi;
    logic [XLEN-1:0]          mres;
    logic [TRANS_ID_BITS-1:0] mtid_i;
    logic                     we;
    logic [4:0]               waddr;
    logic [XLEN-1:0]          wdata;
    logic                     done;
    logic [TRANS_ID_BITS-1:0] dtid;
    logic                     err;

    logic [XLEN-1:0] R [32];   // regfile the DUT reads and writes
    logic [XLEN-1:0] M [32];   // architectural contents expected from the spec rules
    bit              fv;       // forwarding entry expected valid
    logic [4:0]      frd;
    int              total, bad, wr_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rdata[0] = R[raddr[0]];
    assign rdata[1] = R[raddr[1]];

    smaqa_issue_ctrl #(.XLEN(XLEN), .TIMEOUT_CYCLES(T)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(ready),
        .req_rs1_i(rs1), .req_rs2_i(rs2), .req_rd_i(rd), .req_trans_id_i(tid),
        .rf_raddr_o(raddr), .rf_rdata_i(rdata),
        .mult_valid_o(mv), .mult_ready_i(mready),
        .mult_op_a_o(opa), .mult_op_b_o(opb), .mult_op_c_o(opc), .mult_trans_id_o(mtid_o),
        .mult_valid_i(mvi), .mult_result_i(mres), .mult_trans_id_i(mtid_i),
        .rf_we_o(we), .rf_waddr_o(waddr), .rf_wdata_o(wdata),
        .done_valid_o(done), .done_trans_id_o(dtid), .err_o(err)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // rd + sum of four signed byte products, straight from the instruction definition
    function automatic logic [31:0] smaqa_ref(input logic [31:0] a, b, c);
        int s;
        s = 0;
        for (int i = 0; i < 4; i++)
            s += int'($signed(a[8*i +: 8])) * int'($signed(b[8*i +: 8]));
        return c + 32'(s);
    endfunction

    // One clock; a write seen during the cycle lands in the regfile at the edge.
    task automatic step();
        logic pw; logic [4:0] pa; logic [31:0] pd;
        pw = we; pa = waddr; pd = wdata;
        @(posedge clk);
        if (pw) begin
            R[pa] = pd;
            wr_cnt++;
        end
        #1;
    endtask

    task automatic do_op(input logic [4:0] s1, s2, d, input logic [2:0] id,
                         input int rwait, input int lat, input bit respond);
        logic [31:0] ea, eb, ec, er;
        int cyc, w, wr0, exp_iss;
        bit skip;
        ea = (s1 == 0) ? 32'd0 : M[s1];
        eb = (s2 == 0) ? 32'd0 : M[s2];
        ec = (d == 0)  ? 32'd0 : M[d];
        er = smaqa_ref(ea, eb, ec);
`ifdef SMAQA_FWD_EN
        skip = fv && (d == frd) && (d != 0);
`else
        skip = 1'b0;
`endif
        exp_iss = skip ? 2 : 3;
        wr0 = wr_cnt;
        chk("ready_idle", ready, 1);
        req_valid = 1'b1; rs1 = s1; rs2 = s2; rd = d; tid = id;
        step(); cyc = 1;
        req_valid = 1'b0; rs1 = ~s1; rs2 = ~s2; rd = ~d; tid = ~id;
        chk("ready_busy", ready, 0);
        chk("raddr_ab", {raddr[1], raddr[0]}, {s2, s1});
        while (!mv && cyc < 8) begin step(); cyc++; end
        chk("issue_lat", cyc, exp_iss);
        chk("op_a", opa, ea);
        chk("op_b", opb, eb);
        chk("op_c", opc, ec);
        chk("op_tid", mtid_o, id);
        for (int k = 0; k < rwait; k++) begin
            step(); cyc++;
            chk("hold_valid", mv, 1);
            chk("hold_ops", {opa, opb, opc, mtid_o}, {ea, eb, ec, id});
        end
        mready = 1'b1;
        step(); cyc++;
        mready = 1'b0;
        chk("valid_drop", mv, 0);
        if (respond) begin
            for (int k = 0; k < lat - 1; k++) begin
                if (k == 0) begin
                    mvi = 1'b1; mtid_i = id ^ 3'd1; mres = $urandom;
                end
                step(); cyc++;
                mvi = 1'b0;
                chk("no_early_done", done, 0);
            end
            mvi = 1'b1; mtid_i = id; mres = smaqa_ref(opa, opb, opc);
            step(); cyc++;
            mvi = 1'b0;
            chk("done", done, 1);
            chk("done_tid", dtid, id);
            chk("no_err", err, 0);
            chk("we", we, d != 0);
            if (d != 0) begin
                chk("waddr", waddr, d);
                chk("wdata", wdata, er);
                M[d] = er; fv = 1'b1; frd = d;
            end
            if (rwait == 0) chk("done_lat", cyc, exp_iss + lat + 1);
            step();
            chk("done_pulse", done, 0);
            chk("ready_back", ready, 1);
            chk("rf_commit", R[d], M[d]);
            chk("write_cnt", wr_cnt - wr0, (d != 0) ? 1 : 0);
        end else begin
            w = 0;
            while (!err && w < T + 4) begin
                step(); w++;
                if (!err) chk("tmo_no_done", done, 0);
            end
            chk("tmo_cycles", w, T);
            chk("tmo_done", done, 1);
            chk("tmo_we", we, 0);
            fv = 1'b0;
            step();
            chk("err_pulse", err, 0);
            chk("tmo_ready", ready, 1);
            chk("tmo_nowrite", wr_cnt - wr0, 0);
        end
    endtask

    initial begin
        total = 0; bad = 0; wr_cnt = 0; fv = 1'b0; frd = '0;
        rst = 1'b1; req_valid = 1'b0; rs1 = '0; rs2 = '0; rd = '0; tid = '0;
        mready = 1'b0; mvi = 1'b0; mres = '0; mtid_i = '0;
        for (int i = 0; i < 32; i++) R[i] = $urandom;
        R[0] = 32'hDEADBEEF;
        R[1] = 32'h01020304; R[2] = 32'h05060708; R[3] = 32'd9; R[4] = 32'd9;
        for (int i = 0; i < 32; i++) M[i] = R[i];

        step(); step();
        rst = 1'b0;
        chk("rst_ready", ready, 1);
        chk("rst_outs", {mv, we, done, err}, 4'b0);
        chk("rst_raddr", raddr, 10'd0);
        chk("rst_ops", {opa, opb, opc}, 96'd0);

        do_op(5'd1, 5'd2, 5'd3, 3'd1, 0, 2, 1'b1);
        chk("r3_first", R[3], 32'h0000004F);
        do_op(5'd1, 5'd2, 5'd3, 3'd2, 0, 1, 1'b1);
        chk("r3_accum", R[3], 32'h00000095);

        R[1] = 32'hFF020304; M[1] = R[1];
        do_op(5'd1, 5'd2, 5'd4, 3'd3, 0, 1, 1'b1);
        chk("r4_neg", R[4], 32'h00000045);

        do_op(5'd1, 5'd2, 5'd0, 3'd4, 0, 1, 1'b1);   // rd = x0
        do_op(5'd0, 5'd2, 5'd5, 3'd5, 0, 3, 1'b1);   // rs1 = x0
        do_op(5'd1, 5'd2, 5'd6, 3'd6, 3, 1, 1'b1);   // multiplier stalls 3 cycles
        do_op(5'd2, 5'd1, 5'd7, 3'd7, 0, 0, 1'b0);   // never answers
        do_op(5'd1, 5'd2, 5'd8, 3'd0, 0, T, 1'b1);   // result on the last allowed cycle

        // reset while waiting for the multiplier
        begin
            int k, wr0;
            wr0 = wr_cnt;
            req_valid = 1'b1; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd9; tid = 3'd5;
            step(); req_valid = 1'b0;
            k = 0;
            while (!mv && k < 8) begin step(); k++; end
            chk("rst_case_issue", mv, 1);
            mready = 1'b1; step(); mready = 1'b0;
            step(); step();
            rst = 1'b1; step(); rst = 1'b0;
            chk("midrst_ready", ready, 1);
            chk("midrst_quiet", {done, err, mv, we}, 4'b0);
            mvi = 1'b1; mtid_i = 3'd5; mres = 32'h1234;
            step(); mvi = 1'b0;
            chk("stale_ignored", {done, we}, 2'b0);
            step();
            chk("midrst_nowrite", wr_cnt - wr0, 0);
            chk("r9_kept", R[9], M[9]);
            fv = 1'b0;
        end

        for (int n = 0; n < 24; n++)
            do_op(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  3'($urandom), $urandom_range(0, 2), $urandom_range(1, 4), 1'b1);

        for (int i = 1; i < 32; i++) chk("final_rf", R[i], M[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
